reaction_timer: RTL

REACTION_TIMER -- requirements
Module: reaction_timer

---
 rtl/reaction_timer_pkg.sv | 24 ++
 rtl/reaction_timer_if.sv | 22 ++
 rtl/bcd_sevseg.sv | 26 ++
 rtl/reaction_timer_core.sv | 151 +++++++++++++++
 rtl/reaction_timer.sv | 41 ++++
 5 files changed

// File: rtl/reaction_timer_pkg.sv
// Shared types and constants for the reaction timer: FSM states, segment
// glyph constants, and the LFSR feedback definition.
package reaction_timer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RUN,
        DONE,
        FAULT
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h01;

    // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] LFSR_SEED = 8'h01;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// Player-facing signal bundle of the reaction timer: button/show_best in,
// display and status lamps out.
interface reaction_timer_if #(
    parameter int DIGITS = 3
);
    logic                  button;
    logic                  show_best;
    logic [7*DIGITS-1:0]   seg;
    logic                  led;
    logic                  false_start;
    logic                  overflow;

    modport master (
        output button, show_best,
        input  seg, led, false_start, overflow
    );

    modport slave (
        input  button, show_best,
        output seg, led, false_start, overflow
    );
endinterface

// File: rtl/bcd_sevseg.sv
// One BCD digit to active-high seven-segment glyph (bit 6 = a ... bit 0 = g);
// codes 10-15 are blanked.
module bcd_sevseg
    import reaction_timer_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        unique case (value)
            4'd0:    seg = 7'h7E;
            4'd1:    seg = 7'h30;
            4'd2:    seg = 7'h6D;
            4'd3:    seg = 7'h79;
            4'd4:    seg = 7'h33;
            4'd5:    seg = 7'h5B;
            4'd6:    seg = 7'h5F;
            4'd7:    seg = 7'h70;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h7B;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction timer engine: button synchronizer, tick divider, LFSR random wait,
// game FSM and BCD counter. Optional best-time register under BEST_TIME_EN.
module reaction_timer_core
    import reaction_timer_pkg::*;
#(
    parameter int DIGITS      = 3,
    parameter int TICK_DIV    = 50000,
    parameter int MIN_DELAY   = 1000,
    parameter int DELAY_SHIFT = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    reaction_timer_if.slave bus
);

    localparam int TICK_W    = $clog2(TICK_DIV);
    localparam int DELAY_MAX = MIN_DELAY + (255 << DELAY_SHIFT);
    localparam int DELAY_W   = $clog2(DELAY_MAX + 1);

    logic                    sync1, sync2, hist;
    logic                    press;
    logic [TICK_W-1:0]       tick_cnt;
    logic                    tick;
    logic [7:0]              lfsr_q;
    state_e                  state_q, state_d;
    logic [DIGITS-1:0][3:0]  count_q, count_d, count_inc;
    logic [DELAY_W-1:0]      delay_q, delay_d, delay_load;
    logic                    ovf_q, ovf_d;
    logic                    all_nines;
    logic                    carry;
    logic [DIGITS-1:0][3:0]  disp;
    logic [7*DIGITS-1:0]     seg_all;

    assign press      = sync2 & ~hist;
    assign tick       = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign delay_load = DELAY_W'(MIN_DELAY) + (DELAY_W'(lfsr_q) << DELAY_SHIFT);

    always_comb begin
        carry     = 1'b1;
        all_nines = 1'b1;
        count_inc = count_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (count_q[k] != 4'd9) all_nines = 1'b0;
            if (carry) begin
                if (count_q[k] == 4'd9) begin
                    count_inc[k] = 4'd0;
                end else begin
                    count_inc[k] = count_q[k] + 4'd1;
                    carry        = 1'b0;
                end
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        delay_d = delay_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: if (press) begin
                delay_d = delay_load;
                count_d = '0;
                state_d = WAIT;
            end
            WAIT: if (press) begin
                state_d = FAULT;
            end else if (tick) begin
                delay_d = delay_q - 1'b1;
                if (delay_q == DELAY_W'(1)) state_d = RUN;
            end
            RUN: if (press) begin
                state_d = DONE;
            end else if (tick) begin
                if (all_nines) begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    count_d = count_inc;
                end
            end
            DONE, FAULT: if (press) begin
                ovf_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            hist     <= 1'b0;
            tick_cnt <= '0;
            lfsr_q   <= LFSR_SEED;
            state_q  <= IDLE;
            count_q  <= '0;
            delay_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            sync1    <= bus.button;
            sync2    <= sync1;
            hist     <= sync2;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            lfsr_q   <= lfsr_next(lfsr_q);
            state_q  <= state_d;
            count_q  <= count_d;
            delay_q  <= delay_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef BEST_TIME_EN
    logic [DIGITS-1:0][3:0] best_q;

    // Only a press-terminated run can improve the record; overflow never does.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_q <= {DIGITS{4'd9}};
        end else if (state_q == RUN && press && count_q < best_q) begin
            best_q <= count_q;
        end
    end

    assign disp = bus.show_best ? best_q : count_q;
`else
    logic unused_show_best;
    assign unused_show_best = bus.show_best;
    assign disp             = count_q;
`endif

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [6:0] glyph;
        bcd_sevseg u_dec (
            .value (disp[k]),
            .seg   (glyph)
        );
        assign seg_all[7*k +: 7] = (state_q == FAULT) ? SEG_DASH : glyph;
    end

    assign bus.seg         = seg_all;
    assign bus.led         = (state_q == RUN);
    assign bus.false_start = (state_q == FAULT);
    assign bus.overflow    = ovf_q;

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer top: flat player ports bundled onto the internal interface
// feeding the core. Optional best-time feature: define BEST_TIME_EN.
module reaction_timer
    import reaction_timer_pkg::*;
#(
    parameter int DIGITS      = 3,
    parameter int TICK_DIV    = 50000,
    parameter int MIN_DELAY   = 1000,
    parameter int DELAY_SHIFT = 3
) (
    input  logic                clock,
    input  logic                ar,
    input  logic                button,
    input  logic                show_best,
    output logic [7*DIGITS-1:0] seg,
    output logic                led,
    output logic                false_start,
    output logic                overflow
);

    reaction_timer_if #(.DIGITS(DIGITS)) bus ();

    assign bus.button    = button;
    assign bus.show_best = show_best;
    assign seg           = bus.seg;
    assign led           = bus.led;
    assign false_start   = bus.false_start;
    assign overflow      = bus.overflow;

    reaction_timer_core #(
        .DIGITS      (DIGITS),
        .TICK_DIV    (TICK_DIV),
        .MIN_DELAY   (MIN_DELAY),
        .DELAY_SHIFT (DELAY_SHIFT)
    ) u_core (
        .clk   (clock),
        .rst_n (ar),
        .bus   (bus)
    );

endmodule
